// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit: shift-add multiply and
// restoring division, one bit per cycle. Define MULT_DIV_SIGNED_EN for two's-complement operands.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        MDCtrl,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div0
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] opr_q, opr_d;
    logic [63:0] acc_q, acc_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        div0_q, div0_d;
`ifdef MULT_DIV_SIGNED_EN
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
`endif

    logic [31:0] mag_a, mag_b;
`ifdef MULT_DIV_SIGNED_EN
    assign mag_a = a[31] ? (~a + 32'd1) : a;
    assign mag_b = b[31] ? (~b + 32'd1) : b;
`else
    assign mag_a = a;
    assign mag_b = b;
`endif

    // Multiply: acc holds {partial product, remaining multiplier bits};
    // the 33-bit sum keeps the carry that shifts down into the upper word.
    logic [32:0] mul_add;
    logic [63:0] mul_next;
    assign mul_add  = acc_q[0] ? ({1'b0, acc_q[63:32]} + {1'b0, opr_q})
                               : {1'b0, acc_q[63:32]};
    assign mul_next = {mul_add, acc_q[31:1]};

    // Divide: dividend bits leave acc[31] as quotient bits enter acc[0].
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic        div_neg;
    logic [32:0] rem_next;
    logic [31:0] quo_next;
    assign div_shift = {rem_q[31:0], acc_q[31]};
    assign div_diff  = {rem_q, acc_q[31]} - {2'b00, opr_q};
    assign div_neg   = div_diff[33];
    assign rem_next  = div_neg ? div_shift : div_diff[32:0];
    assign quo_next  = {acc_q[30:0], ~div_neg};

    logic [63:0] prod_res;
    logic [31:0] quo_res, rem_res;
`ifdef MULT_DIV_SIGNED_EN
    assign prod_res = neg_res_q ? (~mul_next + 64'd1) : mul_next;
    assign quo_res  = neg_res_q ? (~quo_next + 32'd1) : quo_next;
    assign rem_res  = neg_rem_q ? (~rem_next[31:0] + 32'd1) : rem_next[31:0];
`else
    assign prod_res = mul_next;
    assign quo_res  = quo_next;
    assign rem_res  = rem_next[31:0];
`endif

    // NOTE: every variable gets a default before the case so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opr_d   = opr_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div0_d  = 1'b0;
`ifdef MULT_DIV_SIGNED_EN
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (MDCtrl) begin
                    if (op && (b == 32'd0)) begin
                        div0_d = 1'b1;
                    end else begin
                        opr_d   = op ? mag_b : mag_a;
                        acc_d   = {32'd0, (op ? mag_a : mag_b)};
                        rem_d   = 33'd0;
                        cnt_d   = 6'd0;
                        state_d = op ? DIV : MULT;
`ifdef MULT_DIV_SIGNED_EN
                        neg_res_d = a[31] ^ b[31];
                        neg_rem_d = a[31];
`endif
                    end
                end
            end
            MULT: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = FIN;
                    hi_d    = prod_res[63:32];
                    lo_d    = prod_res[31:0];
                end
            end
            DIV: begin
                acc_d = {acc_q[63:32], quo_next};
                rem_d = rem_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = FIN;
                    hi_d    = rem_res;
                    lo_d    = quo_res;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            opr_q   <= 32'd0;
            acc_q   <= 64'd0;
            rem_q   <= 33'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            div0_q  <= 1'b0;
`ifdef MULT_DIV_SIGNED_EN
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opr_q   <= opr_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div0_q  <= div0_d;
`ifdef MULT_DIV_SIGNED_EN
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q == MULT) || (state_q == DIV);
    assign done = (state_q == FIN);
    assign div0 = div0_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, handshake
// corner sequences and randomized operations against an arithmetic model.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        MDCtrl;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div0;

    int n_cmp  = 0;
    int n_fail = 0;

    mult_div_unit dut (
        .clk    (clk),
        .reset  (reset),
        .MDCtrl (MDCtrl),
        .op     (op),
        .a      (a),
        .b      (b),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done),
        .div0   (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input logic o, input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] eh, output logic [31:0] el);
`ifdef MULT_DIV_SIGNED_EN
        longint sa, sb, p, q, r;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        p  = sa * sb;
        if (!o) begin
            eh = p[63:32];
            el = p[31:0];
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            eh = r[31:0];
            el = q[31:0];
        end
`else
        logic [63:0] p;
        p = {32'd0, av} * {32'd0, bv};
        if (!o) begin
            eh = p[63:32];
            el = p[31:0];
        end else begin
            eh = av % bv;
            el = av / bv;
        end
`endif
    endfunction

    // Starts an operation in the current cycle and checks busy for exactly
    // 32 cycles, then done with the result. Ends in the done cycle.
    task automatic do_op(input logic o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] eh, input logic [31:0] el,
                         input string tag, input int interfere_at);
        int busy_cnt;
        busy_cnt = 0;
        MDCtrl = 1'b1;
        op = o;
        a = av;
        b = bv;
        for (int i = 1; i <= 32; i++) begin
            tick();
            MDCtrl = 1'b0;
            if (i == interfere_at) begin
                MDCtrl = 1'b1;
                op = ~o;
                a = $urandom;
                b = $urandom;
            end
            if (busy === 1'b1 && done === 1'b0) busy_cnt++;
        end
        MDCtrl = 1'b0;
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd32);
        tick();
        check({tag, " busy_done"}, {62'd0, busy, done}, 64'd1);
        check({tag, " hi"}, {32'd0, hi}, {32'd0, eh});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, el});
    endtask

    initial begin
        logic        ro;
        logic [31:0] ra, rb, rh, rl;
        int          stray;

        vecs[0] = '{1'b0, 32'd7, 32'd6, 32'd0, 32'd42};
        vecs[2] = '{1'b1, 32'd100, 32'd7, 32'd2, 32'd14};
        vecs[5] = '{1'b0, 32'd0, 32'd12345, 32'd0, 32'd0};
        vecs[7] = '{1'b1, 32'd5, 32'd9, 32'd5, 32'd0};
        vecs[8] = '{1'b1, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF};
        vecs[9] = '{1'b0, 32'h00010000, 32'h00010000, 32'd1, 32'd0};
`ifdef MULT_DIV_SIGNED_EN
        vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1};
        vecs[3] = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000};
        vecs[6] = '{1'b0, 32'h80000000, 32'd2, 32'hFFFFFFFF, 32'd0};
`else
        vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1};
        vecs[3] = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC};
        vecs[4] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
        vecs[6] = '{1'b0, 32'h80000000, 32'd2, 32'd1, 32'd0};
`endif

        reset = 1'b1;
        MDCtrl = 1'b0;
        op = 1'b0;
        a = 32'd0;
        b = 32'd0;
        tick();
        tick();
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        check("reset_flags", {61'd0, busy, done, div0}, 64'd0);
        reset = 1'b0;
        tick();

        // Directed table; consecutive entries start in each other's done cycle.
        for (int i = 0; i < NVEC; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
                  $sformatf("vec%0d", i), 0);
        end
        tick();

        // Start request mid-operation must be ignored.
        do_op(1'b0, 32'd7, 32'd6, 32'd0, 32'd42, "ignored_start", 5);
        // Back-to-back start in the done cycle.
        do_op(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, "back_to_back", 0);
        tick();
        check("done_one_cycle", {62'd0, busy, done}, 64'd0);

        // Divide by zero is rejected with a single div0 pulse.
        MDCtrl = 1'b1;
        op = 1'b1;
        a = 32'd5;
        b = 32'd0;
        tick();
        MDCtrl = 1'b0;
        check("div0_pulse", {61'd0, div0, busy, done}, 64'd4);
        check("div0_hold", {hi, lo}, {32'd2, 32'd14});
        tick();
        check("div0_clear", {61'd0, div0, busy, done}, 64'd0);
        stray = 0;
        for (int i = 0; i < 35; i++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0 || div0 !== 1'b0) stray++;
        end
        check("div0_no_iter", 64'(stray), 64'd0);

        // Reset in cycle k+10 aborts the multiply.
        MDCtrl = 1'b1;
        op = 1'b0;
        a = 32'd7;
        b = 32'd6;
        tick();
        MDCtrl = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_regs", {hi, lo}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        check("abort_no_done", 64'(stray), 64'd0);

        // Reset wins over a simultaneous start.
        reset = 1'b1;
        MDCtrl = 1'b1;
        op = 1'b0;
        a = 32'd3;
        b = 32'd3;
        tick();
        reset = 1'b0;
        MDCtrl = 1'b0;
        check("reset_priority", {62'd0, busy, done}, 64'd0);
        tick();
        check("reset_priority2", {62'd0, busy, done}, 64'd0);

        // Randomized operations against the model.
        for (int i = 0; i < 30; i++) begin
            ro = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            if (ro && rb[3]) rb = $urandom_range(1, 20);
            if (ro && rb == 32'd0) rb = 32'd1;
            model(ro, ra, rb, rh, rl);
            do_op(ro, ra, rb, rh, rl, $sformatf("rand%0d", i), 0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
